// File: rtl/sdramfifo_pkg.sv
// Shared SDRAM FIFO definitions: geometry, command encodings, timing, reader states, burst address map.
// The writer and reader both decode burst pointers through burst_map so their address layouts always agree.
package sdramfifo_pkg;

  localparam int BANK_WIDTH        = 2;
  localparam int ROW_WIDTH         = 13;
  localparam int COL_WIDTH         = 9;
  localparam int DATA_WIDTH        = 16;
  localparam int BURST_POW_SIZE    = 3;
  localparam int OUTCACHE_POW_SIZE = 6;

  localparam int BA             = BANK_WIDTH + ROW_WIDTH + COL_WIDTH - BURST_POW_SIZE;
  localparam int BURST_LEN      = 1 << BURST_POW_SIZE;
  localparam int OUTCACHE_DEPTH = 1 << OUTCACHE_POW_SIZE;
  localparam int AP_BIT         = 10;

  localparam int CAS_LAT = 2;
  localparam int T_RCD   = 2;
  localparam int T_RP    = 2;

  typedef logic [2:0]               cmd_t;   // {ras, cas, we}, active-low
  typedef logic [OUTCACHE_POW_SIZE:0] cptr_t;

  localparam cmd_t CMD_NOP   = 3'b111;
  localparam cmd_t CMD_ACT   = 3'b011;
  localparam cmd_t CMD_READ  = 3'b101;
  localparam cmd_t CMD_WRITE = 3'b100;
  localparam cmd_t CMD_PRE   = 3'b010;
  localparam cmd_t CMD_REF   = 3'b001;
  localparam cmd_t CMD_MRS   = 3'b000;

  typedef enum logic [5:0] {
    ST_IDLE = 6'b000001,
    ST_REQ  = 6'b000010,
    ST_ACT  = 6'b000100,
    ST_RD   = 6'b001000,
    ST_CAP  = 6'b010000,
    ST_PRE  = 6'b100000
  } state_t;

  typedef struct packed {
    logic [BANK_WIDTH-1:0] ba;
    logic [ROW_WIDTH-1:0]  row;
    logic [COL_WIDTH-1:0]  col;
  } burst_addr_t;

  // Burst pointer layout is {row, bank, colhi}; the column low bits are the in-burst word index.
  function automatic burst_addr_t burst_map(input logic [BA-1:0] p);
    burst_addr_t a;
    a.row = p[BA-1 -: ROW_WIDTH];
    a.ba  = p[COL_WIDTH-BURST_POW_SIZE +: BANK_WIDTH];
    a.col = {p[COL_WIDTH-BURST_POW_SIZE-1:0], {BURST_POW_SIZE{1'b0}}};
    return a;
  endfunction

endpackage

// File: rtl/sdramfifo_reader_if.sv
// Reader-side bundle: writer handshake, shared SDRAM command pins, DQ input and consumer FWFT port.
// slave is the reader's view; master is the view of whatever drives it (writer/arbiter/consumer).
interface sdramfifo_reader_if;
  import sdramfifo_pkg::*;

  logic                  i_init_done;
  logic [BA:0]           i_wr_ptr;
  logic [BA:0]           o_rd_ptr;
  logic                  o_req;
  logic                  i_gnt;
  logic [BANK_WIDTH-1:0] o_sdram_ba;
  logic [ROW_WIDTH-1:0]  o_sdram_addr;
  logic                  o_sdram_ras;
  logic                  o_sdram_cas;
  logic                  o_sdram_we;
  logic [DATA_WIDTH-1:0] i_sdram_data;
  logic                  i_rd;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_empty;

  modport slave (
    input  i_init_done, i_wr_ptr, i_gnt, i_sdram_data, i_rd,
    output o_rd_ptr, o_req, o_sdram_ba, o_sdram_addr, o_sdram_ras, o_sdram_cas, o_sdram_we,
           o_data, o_empty
  );

  modport master (
    output i_init_done, i_wr_ptr, i_gnt, i_sdram_data, i_rd,
    input  o_rd_ptr, o_req, o_sdram_ba, o_sdram_addr, o_sdram_ras, o_sdram_cas, o_sdram_we,
           o_data, o_empty
  );

endinterface

// File: rtl/sdramfifo_outcache.sv
// 64-word FWFT out-cache: write lands on the next edge, head word is a combinational read of mem[rptr].
// Pops while empty are dropped; the writer must check fill before committing a burst.
module sdramfifo_outcache
  import sdramfifo_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  empty,
  output cptr_t                 fill
);

  logic [DATA_WIDTH-1:0] mem [OUTCACHE_DEPTH];
  cptr_t                 wptr;
  cptr_t                 rptr;
  logic                  pop;

  assign empty = (wptr == rptr);
  assign fill  = wptr - rptr;
  assign pop   = rd && !empty;
  assign rdata = empty ? '0 : mem[rptr[OUTCACHE_POW_SIZE-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr)  wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wptr[OUTCACHE_POW_SIZE-1:0]] <= wdata;
  end

endmodule

// File: rtl/sdramfifo_reader.sv
// SDRAM FIFO read side: one ACTIVE + READ/auto-precharge burst at a time into the out-cache.
// A burst only starts when the cache can absorb all of it, so capture never has to stall.
module sdramfifo_reader
  import sdramfifo_pkg::*;
(
  input logic               i_clk,
  input logic               i_rst_n,
  sdramfifo_reader_if.slave bus
);

  typedef logic [3:0] cnt_t;

  localparam cptr_t FILL_MAX = cptr_t'(OUTCACHE_DEPTH - BURST_LEN);

  state_t                state, state_nxt;
  cnt_t                  cnt, cnt_nxt;
  cmd_t                  cmd, cmd_nxt;
  logic [BANK_WIDTH-1:0] ba, ba_nxt;
  logic [ROW_WIDTH-1:0]  addr, addr_nxt;
  logic [BA:0]           rd_ptr;
  logic                  adv;
  logic                  cap_wr;
  cptr_t                 fill;
  burst_addr_t           baddr;

  assign baddr = burst_map(rd_ptr[BA-1:0]);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    cmd_nxt   = CMD_NOP;
    ba_nxt    = ba;
    addr_nxt  = addr;
    adv       = 1'b0;
    cap_wr    = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (bus.i_init_done && (bus.i_wr_ptr != rd_ptr) && (fill <= FILL_MAX))
          state_nxt = ST_REQ;
      end
      ST_REQ: begin
        cnt_nxt = '0;
        // ACTIVE goes out on the grant edge itself, no extra bubble.
        if (bus.i_gnt) begin
          state_nxt = ST_ACT;
          cmd_nxt   = CMD_ACT;
          ba_nxt    = baddr.ba;
          addr_nxt  = baddr.row;
        end
      end
      ST_ACT: begin
        if (cnt == cnt_t'(T_RCD - 2)) begin
          state_nxt = ST_RD;
          cnt_nxt   = '0;
        end
      end
      ST_RD: begin
        state_nxt                = ST_CAP;
        cnt_nxt                  = '0;
        cmd_nxt                  = CMD_READ;
        ba_nxt                   = baddr.ba;
        addr_nxt                 = '0;
        addr_nxt[AP_BIT]         = 1'b1;
        addr_nxt[COL_WIDTH-1:0]  = baddr.col;
      end
      ST_CAP: begin
        // cnt 0 ends on the edge the SDRAM latches READ; data follows CAS_LAT edges later.
        cap_wr = (cnt >= cnt_t'(CAS_LAT));
        if (cnt == cnt_t'(CAS_LAT + BURST_LEN - 1)) begin
          state_nxt = ST_PRE;
          cnt_nxt   = '0;
        end
      end
      ST_PRE: begin
        if (cnt == cnt_t'(T_RP - 1)) begin
          state_nxt = ST_IDLE;
          adv       = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      cmd    <= CMD_NOP;
      ba     <= '0;
      addr   <= '0;
      rd_ptr <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      cmd   <= cmd_nxt;
      ba    <= ba_nxt;
      addr  <= addr_nxt;
      if (adv) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign bus.o_req        = (state != ST_IDLE);
  assign bus.o_rd_ptr     = rd_ptr;
  assign bus.o_sdram_ba   = ba;
  assign bus.o_sdram_addr = addr;
  assign {bus.o_sdram_ras, bus.o_sdram_cas, bus.o_sdram_we} = cmd;

  sdramfifo_outcache u_cache (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .wr    (cap_wr),
    .wdata (bus.i_sdram_data),
    .rd    (bus.i_rd),
    .rdata (bus.o_data),
    .empty (bus.o_empty),
    .fill  (fill)
  );

endmodule

// File: tb/tb_sdramfifo_reader.sv
// Bench for sdramfifo_reader: SDRAM + arbiter model on the falling edge, directed steps with a word scoreboard.
// Burst p holds words 0x1000 + 8*p + j, so every captured word identifies its burst and slot.
module tb_sdramfifo_reader;
  import sdramfifo_pkg::*;

  logic clk = 1'b1;
  logic rst_n;
  always #5 clk = ~clk;

  sdramfifo_reader_if bus_if ();

  sdramfifo_reader dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus_if.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc++;

  int act_n = 0, rd_n = 0, act_cyc = 0, rd_cyc = 0, req_cyc = 0, gnt_cyc = 0;
  logic [BANK_WIDTH-1:0] act_ba, rd_ba;
  logic [ROW_WIDTH-1:0]  act_row, rd_addr, cur_row;
  int   gnt_delay = 0, gnt_wait = 0;
  logic req_prev = 1'b0;
  logic m_busy = 1'b0;
  int   m_k = 0;
  logic [BA-1:0] m_p;

  function automatic logic [15:0] word_of(input logic [BA-1:0] p, input int j);
    return 16'h1000 + {p[12:0], 3'b000} + 16'(j);
  endfunction

  // SDRAM device, command monitor and bus arbiter, all acting on the falling edge.
  always @(negedge clk) begin
    logic [2:0] c;
    c = {bus_if.o_sdram_ras, bus_if.o_sdram_cas, bus_if.o_sdram_we};
    if (bus_if.o_req && !req_prev) req_cyc = cyc;
    req_prev = bus_if.o_req;
    if (!bus_if.o_req) begin
      bus_if.i_gnt = 1'b0;
      gnt_wait     = 0;
    end else if (!bus_if.i_gnt) begin
      if (gnt_wait >= gnt_delay) begin
        bus_if.i_gnt = 1'b1;
        gnt_cyc      = cyc;
      end else gnt_wait++;
    end
    if (c == 3'b011) begin
      act_n++; act_cyc = cyc; act_ba = bus_if.o_sdram_ba; act_row = bus_if.o_sdram_addr;
      cur_row = bus_if.o_sdram_addr;
    end
    if (c == 3'b101) begin
      rd_n++; rd_cyc = cyc; rd_ba = bus_if.o_sdram_ba; rd_addr = bus_if.o_sdram_addr;
      m_p = {cur_row, bus_if.o_sdram_ba, bus_if.o_sdram_addr[8:3]};
      m_busy = 1'b1; m_k = 0;
    end else if (m_busy) begin
      m_k++;
      if (m_k > 9) m_busy = 1'b0;
    end
    bus_if.i_sdram_data = (m_busy && m_k >= 2 && m_k <= 9) ? word_of(m_p, m_k - 2) : 16'hDEAD;
  end

  logic [15:0] exp_q[$];
  logic [BA:0] wr_ptr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic commit(input int n);
    for (int b = 0; b < n; b++)
      for (int j = 0; j < BURST_LEN; j++) exp_q.push_back(word_of(wr_ptr[BA-1:0] + BA'(b), j));
    wr_ptr = wr_ptr + (BA+1)'(n);
    bus_if.i_wr_ptr = wr_ptr;
  endtask

  task automatic pop_words(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      logic [15:0] e;
      while (bus_if.o_empty && t < 300) begin step(); t++; end
      if (bus_if.o_empty) begin
        chk({tag, "_timeout"}, 32'd1, 32'd0);
        return;
      end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hBEEF;
      chk(tag, bus_if.o_data, e);
      bus_if.i_rd = 1'b1;
      step();
      bus_if.i_rd = 1'b0;
    end
  endtask

  task automatic wait_act(input int prev, input string tag);
    int t = 0;
    while (act_n == prev && t < 500) begin step(); t++; end
    chk({tag, "_act"}, act_n - prev, 1);
  endtask

  task automatic wait_rd(input int prev, input string tag);
    int t = 0;
    while (rd_n == prev && t < 50) begin step(); t++; end
    chk({tag, "_read"}, rd_n - prev, 1);
  endtask

  task automatic wait_rdptr(input logic [BA:0] v, input string tag);
    int t = 0;
    while (bus_if.o_rd_ptr !== v && t < 500) begin step(); t++; end
    chk(tag, bus_if.o_rd_ptr, v);
  endtask

  initial begin
    int a0, r0, viol, t;
    burst_addr_t m;

    // Reset state, then a long idle with nothing committed
    rst_n = 1'b0; wr_ptr = '0;
    bus_if.i_wr_ptr = wr_ptr; bus_if.i_init_done = 1'b1; bus_if.i_rd = 1'b0;
    step(); step();
    chk("rst_req", bus_if.o_req, 0);
    chk("rst_pins", {bus_if.o_sdram_ras, bus_if.o_sdram_cas, bus_if.o_sdram_we}, 3'b111);
    chk("rst_ba", bus_if.o_sdram_ba, 0);
    chk("rst_addr", bus_if.o_sdram_addr, 0);
    chk("rst_rdptr", bus_if.o_rd_ptr, 0);
    chk("rst_empty", bus_if.o_empty, 1);
    chk("rst_data", bus_if.o_data, 0);
    rst_n = 1'b1;
    viol = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (bus_if.o_req !== 1'b0 || bus_if.o_empty !== 1'b1 ||
          {bus_if.o_sdram_ras, bus_if.o_sdram_cas, bus_if.o_sdram_we} !== 3'b111) viol++;
    end
    chk("idle100_viol", viol, 0);

    // Single burst; init_done low must hold it off
    bus_if.i_init_done = 1'b0;
    a0 = act_n; r0 = rd_n;
    commit(1);
    for (int i = 0; i < 20; i++) step();
    chk("noinit_req", bus_if.o_req, 0);
    bus_if.i_init_done = 1'b1;
    wait_act(a0, "b0");
    chk("b0_act_ba", act_ba, 0);
    chk("b0_act_row", act_row, 0);
    chk("b0_gnt_to_act", act_cyc - gnt_cyc, 1);
    wait_rd(r0, "b0");
    chk("b0_rd_addr", rd_addr, 13'h400);
    chk("b0_rd_ba", rd_ba, 0);
    chk("b0_act_to_rd", rd_cyc - act_cyc, 2);
    wait_rdptr(22'd1, "b0_rdptr");
    step(); step();
    chk("b0_req_drop", bus_if.o_req, 0);
    pop_words(8, "b0_word");
    chk("b0_empty_after", bus_if.o_empty, 1);

    // No consumer: reading stops once the cache can no longer take a whole burst
    a0 = act_n;
    commit(20);
    for (int i = 0; i < 400; i++) step();
    chk("full_bursts", act_n - a0, 8);
    chk("full_rdptr", bus_if.o_rd_ptr, 22'd9);
    pop_words(7, "full_word");
    for (int i = 0; i < 40; i++) step();
    chk("fill57_no_act", act_n - a0, 8);
    chk("fill57_req", bus_if.o_req, 0);
    pop_words(1, "full_word");
    wait_act(a0 + 8, "fill56");
    pop_words(152, "drain_word");
    wait_rdptr(22'd21, "drain_rdptr");
    chk("drain_empty", bus_if.o_empty, 1);
    chk("drain_q", exp_q.size(), 0);

    // Late grant
    gnt_delay = 5;
    a0 = act_n; r0 = rd_n;
    commit(1);
    wait_act(a0, "late");
    chk("late_req_to_act", act_cyc - req_cyc, 6);
    chk("late_gnt_to_act", act_cyc - gnt_cyc, 1);
    wait_rd(r0, "late");
    chk("late_rd_addr", rd_addr, 13'h4A8);
    pop_words(8, "late_word");
    gnt_delay = 0;

    // Address map at the top of the burst space, and a wrap-bit-only pointer difference
    m = burst_map(21'h1FFFFF);
    chk("map_top_ba", m.ba, 3);
    chk("map_top_row", m.row, 13'h1FFF);
    chk("map_top_col", m.col, 9'h1F8);
    m = burst_map(21'h0A5A5A);
    chk("map_mid_ba", m.ba, 1);
    chk("map_mid_row", m.row, 13'h0A5A);
    chk("map_mid_col", m.col, 9'h0D0);
    a0 = act_n; r0 = rd_n;
    wr_ptr = 22'h200016;
    bus_if.i_wr_ptr = wr_ptr;
    wait_act(a0, "wrap");
    wait_rd(r0, "wrap");
    chk("wrap_rd_addr", rd_addr, 13'h4B0);
    wait_rdptr(22'd23, "wrap_rdptr");

    // Reset in the middle of a burst's capture
    rst_n = 1'b0;
    wr_ptr = '0; bus_if.i_wr_ptr = wr_ptr;
    exp_q.delete();
    step(); step(); step();
    rst_n = 1'b1;
    step();
    a0 = act_n; r0 = rd_n;
    commit(1);
    t = 0;
    while (!(m_busy && m_k == 5) && t < 500) begin step(); t++; end
    chk("mid_word3_reached", m_k, 5);
    chk("mid_pre_empty", bus_if.o_empty, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_pins", {bus_if.o_sdram_ras, bus_if.o_sdram_cas, bus_if.o_sdram_we}, 3'b111);
    chk("mid_req", bus_if.o_req, 0);
    chk("mid_rdptr", bus_if.o_rd_ptr, 0);
    chk("mid_empty", bus_if.o_empty, 1);
    step(); step();
    rst_n = 1'b1;
    wait_act(a0 + 1, "reread");
    chk("reread_act_row", act_row, 0);
    chk("reread_act_ba", act_ba, 0);
    wait_rd(r0 + 1, "reread");
    chk("reread_rd_addr", rd_addr, 13'h400);
    pop_words(8, "reread_word");
    wait_rdptr(22'd1, "reread_rdptr");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
